count_ones_sched: RTL and testbench
===================================

Name: count_ones_sched

Overview:
- Round-robin scheduler that shares one count-ones compute unit (go/done FSM plus n/count datapath) between NUM_REQ requesters.
- Accepts a job from one requester and launches it on the unit with a single-cycle go.
- Waits for done, captures the result, and returns it to the same requester over a valid/ready response channel.
- Sits between client blocks and the single count-ones unit; it is the only driver of the unit's go and operand.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width in bits.
- CW, $clog2(WIDTH+1), result/count width.
- TIMEOUT, WIDTH+8, max cycles in WAIT before the job is aborted with error.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  per-requester job request.
- req_data  in  NUM_REQ*WIDTH  per-requester operand; slice i = bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot accept strobe; a job transfers when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot response valid to the job owner.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_count  out  CW  result count, shared by all requesters.
- rsp_error  out  1  high with rsp_valid when the job timed out.
- cu_go  out  1  go to the compute unit.
- cu_data  out  WIDTH  operand to the compute unit, registered.
- cu_done  in  1  done from the compute unit.
- cu_result  in  CW  count output register of the unit, valid while cu_done=1.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last job owner.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, grant_id=0, cu_go=0, cu_data=0, req_ready=0, rsp_valid=0, rsp_count=0, rsp_error=0, busy=0, timer=0.
- States: IDLE, ISSUE, ARM, WAIT, DELIVER.
- IDLE:
  - If any req_valid, select the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[sel]=1 (combinational, only in IDLE); register cu_data<=req_data[sel] and grant_id<=sel; go to ISSUE.
- ISSUE: cu_go=1 for exactly this one cycle; go to ARM.
- ARM: cu_go=0; cu_done is ignored for this cycle (masks the stale done held over from the previous job); timer<=0; go to WAIT.
- WAIT:
  - timer increments every cycle.
  - If cu_done=1: rsp_count<=cu_result, rsp_error<=0, go to DELIVER.
  - Else if timer==TIMEOUT-1: rsp_count<=0, rsp_error<=1, go to DELIVER.
  - cu_done takes priority over timeout in the same cycle.
- DELIVER:
  - rsp_valid[grant_id]=1; rsp_count and rsp_error held stable.
  - On rsp_ready[grant_id]=1: rr_ptr<=grant_id+1 (wraps to 0 past NUM_REQ-1), go to IDLE.
  - rsp_ready on any other index is ignored.
- Fairness: rr_ptr advances only after a completed delivery. A requester holding req_valid is granted within NUM_REQ jobs.
- Zero operand: the unit may assert done on the first WAIT cycle. It is accepted; result 0.
- The unit keeps done=1 after completion until the next go. The scheduler issues no further go until the next job, so the unit is never restarted mid-compute.
- req_valid deasserting in any state other than IDLE has no effect; the operand was captured at accept.
- Back-to-back jobs: IDLE -> ISSUE minimum. Minimum accept-to-response latency is 4 cycles (accept, ISSUE, ARM, WAIT with done).
- Reset asserted mid-job: returns to IDLE immediately and the in-flight result is discarded. The unit is expected to be reset by the same rst.

Test Plan:
- Single job: req_valid[0]=1, req_data=16'h00F3 -> req_ready[0] pulses 1 cycle, cu_go pulses once with cu_data=16'h00F3; after unit done, rsp_valid[0]=1, rsp_count=6, rsp_error=0.
- Round robin: req_valid=4'b1111 held, rsp_ready tied 1 -> grant order 0,1,2,3,0; rsp_valid one-hot each time.
- Backpressure: rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] and rsp_count held; no req_ready; no cu_go until rsp_ready[2]=1.
- Zero operand and stale done: job A=16'hFFFF (count 16), then job B=0 -> B returns 0, not 16 (stale done masked in ARM).
- Timeout: cu_done stuck 0 -> after TIMEOUT=24 WAIT cycles, rsp_valid set, rsp_error=1, rsp_count=0; next job proceeds normally.
- Async reset in WAIT: rst=0 between edges -> busy, rsp_valid and cu_go drop immediately; after release, rr_ptr=0 and requester 0 wins first.

Source files
------------

// File: rtl/count_ones_sched.sv
// Round-robin scheduler sharing one count-ones unit between NUM_REQ requesters.
// Launches a job with a one-cycle go, waits for done or timeout, returns result.
module count_ones_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int CW      = $clog2(WIDTH + 1),
    parameter int TIMEOUT = WIDTH + 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [CW-1:0]              rsp_count,
    output logic                       rsp_error,
    output logic                       cu_go,
    output logic [WIDTH-1:0]           cu_data,
    input  logic                       cu_done,
    input  logic [CW-1:0]              cu_result,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0] NR = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        r_grant;
    logic [TW-1:0]        r_timer;
    logic [WIDTH-1:0]     r_cu_data;
    logic [CW-1:0]        r_count;
    logic                 r_error;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_any;
    logic [IW-1:0]        w_off;
    logic [IW:0]          w_sum;
    logic [IW-1:0]        w_sel;
    logic [WIDTH-1:0]     w_opnd;
    logic [NUM_REQ-1:0]   w_req_ready;
    logic                 w_timeout;

    // Rotate requests so rr_ptr lands at bit 0; lowest set bit wins.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NUM_REQ'(w_dbl >> r_rr_ptr);
    assign w_any = |req_valid;

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sel = (w_sum >= NR) ? IW'(w_sum - NR) : IW'(w_sum);

    always_comb begin
        w_opnd = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == IW'(k)) begin
                w_opnd = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_timeout = (r_timer == TLIM);

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_req_ready = NUM_REQ'(1) << w_sel;
                    w_next      = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_ARM;
            S_ARM:   w_next = S_WAIT;
            S_WAIT: begin
                if (cu_done || w_timeout) begin
                    w_next = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (rsp_ready[r_grant]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_timer   <= '0;
            r_cu_data <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cu_data <= w_opnd;
                        r_grant   <= w_sel;
                    end
                end
                // Done is ignored here: it may still be high from the last job.
                S_ARM: r_timer <= '0;
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (cu_done) begin
                        r_count <= cu_result;
                        r_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_count <= '0;
                        r_error <= 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (rsp_ready[r_grant]) begin
                        r_rr_ptr <= (r_grant == LAST) ? '0 : r_grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == S_DELIVER) ? NUM_REQ'(1) << r_grant : '0;
    assign rsp_count = r_count;
    assign rsp_error = r_error;
    assign cu_go     = (r_state == S_ISSUE);
    assign cu_data   = r_cu_data;
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_count_ones_sched.sv
// Scoreboard bench for count_ones_sched with a behavioural count-ones unit.
// Directed jobs push expected responses; a monitor pops on each response transfer.
module tb_count_ones_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [CW-1:0]  rsp_count;
    logic           rsp_error;
    logic           cu_go;
    logic [W-1:0]   cu_data;
    logic           cu_done;
    logic [CW-1:0]  cu_result;
    logic           busy;
    logic [1:0]     grant_id;

    count_ones_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_count(rsp_count), .rsp_error(rsp_error),
        .cu_go(cu_go), .cu_data(cu_data),
        .cu_done(cu_done), .cu_result(cu_result),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Count-ones unit: done drops one cycle after go unless latency is 0,
    // then stays high until the next go. A stuck unit never finishes.
    int u_lat = 1;
    bit stuck = 1'b0;
    logic u_pend;
    int   u_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cu_done   <= 1'b0;
            cu_result <= '0;
            u_pend    <= 1'b0;
            u_cnt     <= 0;
        end else if (cu_go) begin
            u_pend <= 1'b1;
            u_cnt  <= u_lat;
        end else if (u_pend && stuck) begin
            cu_done <= 1'b0;
        end else if (u_pend) begin
            if (u_cnt == 0) begin
                cu_done   <= 1'b1;
                cu_result <= CW'($countones(cu_data));
                u_pend    <= 1'b0;
            end else begin
                cu_done <= 1'b0;
                u_cnt   <= u_cnt - 1;
            end
        end
    end

    typedef struct {
        int id;
        int cnt;
        int err;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int id, input int cnt, input int err);
        exp_t e;
        e.id  = id;
        e.cnt = cnt;
        e.err = err;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && rsp_valid != '0) begin
                chk("rsp_onehot", $countones(rsp_valid), 1);
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        if (q.size() == 0) begin
                            chk("unexpected_rsp", i, -1);
                        end else begin
                            e = q.pop_front();
                            chk("rsp_id", i, e.id);
                            chk("rsp_count", int'(rsp_count), e.cnt);
                            chk("rsp_error", int'(rsp_error), e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] d, input int lat,
                        output int lat_o);
        bit acc = 1'b0;
        u_lat = lat;
        @(negedge clk);
        req_valid[id] = 1'b1;
        req_data[id*W +: W] = d;
        for (int k = 0; k < 200 && !acc; k++) begin
            #1;
            if (req_ready[id]) acc = 1'b1;
            else @(negedge clk);
        end
        chk("accept", int'(acc), 1);
        chk("req_ready_onehot", int'(req_ready), 1 << id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        chk("issue_go", int'(cu_go), 1);
        chk("issue_data", int'(cu_data), int'(d));
        chk("issue_grant", int'(grant_id), id);
        chk("issue_no_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        chk("arm_go_low", int'(cu_go), 0);
        lat_o = 1;
        while (!rsp_valid[id] && lat_o < 100) begin
            @(posedge clk);
            #1;
            lat_o++;
        end
    endtask

    task automatic run_held(input logic [N-1:0] mask, input int n,
                            output logic [N-1:0] first);
        int acc = 0;
        u_lat = 1;
        first = '0;
        @(negedge clk);
        req_valid = mask;
        for (int k = 0; k < 500 && acc < n; k++) begin
            #1;
            if (req_ready != '0) begin
                if (acc == 0) first = req_ready;
                acc++;
                @(posedge clk);
                #1;
                if (acc == n) req_valid = '0;
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("held_accepts", acc, n);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_q_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int lat;
    logic [N-1:0] first;

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '1;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cu_go", int'(cu_go), 0);
        chk("rst_cu_data", int'(cu_data), 0);
        chk("rst_rsp_count", int'(rsp_count), 0);
        chk("rst_rsp_error", int'(rsp_error), 0);
        chk("rst_grant", int'(grant_id), 0);
        @(negedge clk);
        rst = 1'b1;

        // Single job: 0x00F3 has six ones.
        push(0, 6, 0);
        send(0, 16'h00F3, 2, lat);
        drain();

        // Round robin from a fresh pointer.
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        req_data = {16'hFFFF, 16'h7000, 16'h0303, 16'h0001};
        push(0, 1, 0);
        push(1, 4, 0);
        push(2, 3, 0);
        push(3, 16, 0);
        push(0, 1, 0);
        run_held(4'b1111, 5, first);
        chk("rr_first", int'(first), 1);
        drain();

        // Backpressure on requester 2 while requester 0 waits.
        rsp_ready = 4'b1011;
        push(2, 8, 0);
        push(0, 4, 0);
        send(2, 16'hA5A5, 1, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_data[0 +: W] = 16'h000F;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_rsp_valid", int'(rsp_valid), 4);
            chk("bp_rsp_count", int'(rsp_count), 8);
            chk("bp_no_ready", int'(req_ready), 0);
            chk("bp_no_go", int'(cu_go), 0);
            @(negedge clk);
        end
        rsp_ready = '1;
        begin
            bit acc = 1'b0;
            for (int k = 0; k < 50 && !acc; k++) begin
                @(negedge clk);
                #1;
                if (req_ready[0]) acc = 1'b1;
            end
            chk("bp_next_accept", int'(acc), 1);
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
        end
        drain();

        // Full operand, then zero operand behind a stale done.
        push(1, 16, 0);
        send(1, 16'hFFFF, 3, lat);
        drain();
        push(1, 0, 0);
        send(1, 16'h0000, 0, lat);
        chk("zero_latency", lat, 3);
        drain();

        // Stuck unit times out, next job is normal.
        stuck = 1'b1;
        push(2, 0, 1);
        send(2, 16'h00FF, 1, lat);
        chk("timeout_latency", lat, 26);
        drain();
        stuck = 1'b0;
        push(2, 8, 0);
        send(2, 16'h0F0F, 2, lat);
        drain();

        // Async reset during WAIT on a job from requester 1.
        u_lat = 5;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_data[W +: W] = 16'h00F0;
        #1;
        chk("ar_accept", int'(req_ready), 2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("ar_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_rsp_valid", int'(rsp_valid), 0);
        chk("ar_cu_go", int'(cu_go), 0);
        chk("ar_grant", int'(grant_id), 0);
        @(negedge clk);
        rst = 1'b1;
        req_data[0 +: W] = 16'h0101;
        req_data[3*W +: W] = 16'hF000;
        push(0, 2, 0);
        push(3, 4, 0);
        run_held(4'b1001, 2, first);
        chk("ar_first_winner", int'(first), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
